// File: rtl/uart_rx_sequencer.sv
// Purpose: deframe an oversampled serial line into parallel words, steering the upstream tick counter.
// Latency: tick_clear 3 cycles after the start edge is sampled; word valid one cycle after the mid-stop sample.
// Backpressure: none; a word not taken via data_read before the next good frame is overwritten and flagged as overrun.
module uart_rx_sequencer #(
  parameter int NUM_DATA_BITS = 8,
  parameter int OVERSAMPLE    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     serial_in,
  input  logic                     sample_tick,
  output logic                     tick_clear,
  output logic                     tick_enable,
  input  logic                     data_read,
  output logic [NUM_DATA_BITS-1:0] data_out,
  output logic                     data_ready,
  output logic                     framing_error,
  output logic                     overrun_error,
  output logic                     busy
);

  localparam int TW = $clog2(OVERSAMPLE) + 1;
  localparam int BW = $clog2(NUM_DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_BIT = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] FULL_BIT = TW'(OVERSAMPLE);
  localparam logic [BW-1:0] LAST_BIT = BW'(NUM_DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                   state;
  logic                     sync1, sync2, hist;
  logic [TW-1:0]            tick_cnt;
  logic [BW-1:0]            bit_cnt;
  logic [NUM_DATA_BITS-1:0] shift_reg;
  logic [TW-1:0]            tick_next;
  logic                     fall_edge;

  // The history flop runs while busy too, so an edge hidden under a low stop bit is never seen until the line returns high.
  assign fall_edge = hist & ~sync2;
  assign tick_next = tick_cnt + TW'(1);

  // Two-flop synchroniser for the asynchronous line, then one history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
    end else begin
      sync1 <= serial_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // Frame sequencer: counts ticks within each bit, samples mid-bit, and owns all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tick_clear    <= 1'b0;
      tick_enable   <= 1'b0;
      busy          <= 1'b0;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      data_out      <= '0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      tick_clear <= 1'b0;

      // A read acknowledges the held word; a good stop later in this block takes priority on data_ready.
      if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (fall_edge) begin
            tick_clear    <= 1'b1;
            tick_enable   <= 1'b1;
            busy          <= 1'b1;
            tick_cnt      <= '0;
            framing_error <= 1'b0;
            state         <= START;
          end
        end

        START: begin
          if (sample_tick) begin
            if (tick_next == HALF_BIT) begin
              tick_cnt <= '0;
              if (!sync2) begin
                bit_cnt <= '0;
                state   <= DATA;
              end else begin
                // Line back high at mid-start: glitch, drop it quietly.
                tick_enable <= 1'b0;
                busy        <= 1'b0;
                state       <= IDLE;
              end
            end else begin
              tick_cnt <= tick_next;
            end
          end
        end

        DATA: begin
          if (sample_tick) begin
            if (tick_next == FULL_BIT) begin
              tick_cnt  <= '0;
              shift_reg <= {sync2, shift_reg[NUM_DATA_BITS-1:1]};
              bit_cnt   <= bit_cnt + BW'(1);
              if (bit_cnt == LAST_BIT) begin
                state <= STOP;
              end
            end else begin
              tick_cnt <= tick_next;
            end
          end
        end

        STOP: begin
          if (sample_tick) begin
            if (tick_next == FULL_BIT) begin
              if (sync2) begin
                data_out   <= shift_reg;
                data_ready <= 1'b1;
                if (data_ready && !data_read) begin
                  overrun_error <= 1'b1;
                end
              end else begin
                framing_error <= 1'b1;
              end
              tick_cnt    <= '0;
              tick_enable <= 1'b0;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              tick_cnt <= tick_next;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Bench for uart_rx_sequencer: frames are driven with one sample tick per clock,
// expected status snapshots and tick_clear cycles go into queues, and a negedge
// monitor pops and compares whenever a frame ends, a read lands, or tick_clear fires.
module tb_uart_rx_sequencer;

  localparam int N         = 8;
  localparam int OS        = 4;
  localparam int FRAME_CYC = OS * (N + 2);
  // Edge detect takes 3 cycles, then half a bit to mid-start, then N data bits and the stop bit.
  localparam int DONE_CYC  = 3 + OS / 2 + OS * (N + 1);

  logic         tb_clk = 1'b0;
  logic         rst;
  logic         serial_in;
  logic         sample_tick;
  logic         data_read;
  logic         tick_clear;
  logic         tick_enable;
  logic [N-1:0] data_out;
  logic         data_ready;
  logic         framing_error;
  logic         overrun_error;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [N-1:0] data;
    logic         ready;
    logic         fe;
    logic         oe;
  } res_t;

  res_t res_q[$];
  int   tc_q[$];

  // Reference model of the consumer-visible status.
  logic [N-1:0] m_data;
  logic         m_ready, m_fe, m_oe;

  uart_rx_sequencer #(.NUM_DATA_BITS(N), .OVERSAMPLE(OS)) dut (
    .clk           (tb_clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .sample_tick   (sample_tick),
    .tick_clear    (tick_clear),
    .tick_enable   (tick_enable),
    .data_read     (data_read),
    .data_out      (data_out),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .busy          (busy)
  );

  initial forever #5 tb_clk = ~tb_clk;
  initial forever begin
    @(posedge tb_clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic gap(input int n);
    serial_in = 1'b1;
    repeat (n) tick();
  endtask

  task automatic push_state();
    res_t r;
    r.data  = m_data;
    r.ready = m_ready;
    r.fe    = m_fe;
    r.oe    = m_oe;
    res_q.push_back(r);
  endtask

  task automatic model_reset();
    m_data  = '0;
    m_ready = 1'b0;
    m_fe    = 1'b0;
    m_oe    = 1'b0;
  endtask

  // Drives one frame; returns early without any result when abort_at is reached.
  task automatic send_frame(input logic [N-1:0] b, input logic stop, input logic rd, input int abort_at);
    logic [N+1:0] bits;
    bits = {stop, b, 1'b0};
    tc_q.push_back(cyc + 3);
    for (int c = 0; c < FRAME_CYC; c++) begin
      if (c == abort_at) return;
      serial_in = bits[c/OS];
      tick();
    end
    for (int c = FRAME_CYC; c < DONE_CYC; c++) begin
      serial_in = 1'b1;
      data_read = rd && (c == DONE_CYC - 1);
      tick();
    end
    data_read = 1'b0;
    if (stop) begin
      if (rd)           m_oe = 1'b0;
      else if (m_ready) m_oe = 1'b1;
      m_data  = b;
      m_ready = 1'b1;
      m_fe    = 1'b0;
    end else begin
      m_fe = 1'b1;
      if (rd) begin
        m_ready = 1'b0;
        m_oe    = 1'b0;
      end
    end
    push_state();
  endtask

  task automatic read_pulse();
    data_read = 1'b1;
    m_ready   = 1'b0;
    m_oe      = 1'b0;
    push_state();
    tick();
    data_read = 1'b0;
  endtask

  task automatic false_start();
    tc_q.push_back(cyc + 3);
    m_fe = 1'b0;
    push_state();
    serial_in = 1'b0;
    tick();
    serial_in = 1'b1;
    repeat (8) tick();
  endtask

  // Monitor: compares against the queued expectations whenever the DUT produces an event.
  logic prev_busy = 1'b0;
  logic prev_read = 1'b0;
  int   mon_e;
  res_t mon_r;
  initial forever begin
    @(negedge tb_clk);
    if (rst) begin
      prev_busy = 1'b0;
      prev_read = 1'b0;
    end else begin
      if (tick_clear) begin
        if (tc_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tick_clear_unexpected: got pulse at cycle %0d, expected none", cyc);
        end else begin
          mon_e = tc_q.pop_front();
          check("tick_clear_cycle", 32'(cyc), 32'(mon_e));
          check("start_clears_framing", 32'(framing_error), 32'h0);
          check("start_busy_enable", 32'({busy, tick_enable}), 32'h3);
        end
      end
      if ((prev_busy && !busy) || prev_read) begin
        if (res_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL result_unexpected: got event at cycle %0d, expected none", cyc);
        end else begin
          mon_r = res_q.pop_front();
          check("result_data_out", 32'(data_out), 32'(mon_r.data));
          check("result_data_ready", 32'(data_ready), 32'(mon_r.ready));
          check("result_framing_error", 32'(framing_error), 32'(mon_r.fe));
          check("result_overrun_error", 32'(overrun_error), 32'(mon_r.oe));
          check("result_enable_low", 32'(tick_enable), 32'h0);
        end
      end
      prev_busy = busy;
      prev_read = data_read;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by %0t, expected completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] rb;
    logic         rs, rr;
    rst         = 1'b1;
    serial_in   = 1'b1;
    sample_tick = 1'b1;
    data_read   = 1'b0;
    model_reset();

    // Reset held with a toggling line.
    repeat (4) begin
      #5;
      serial_in = ~serial_in;
    end
    #1;
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_data_ready", 32'(data_ready), 32'h0);
    check("reset_framing", 32'(framing_error), 32'h0);
    check("reset_overrun", 32'(overrun_error), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_tick_enable", 32'(tick_enable), 32'h0);
    check("reset_tick_clear", 32'(tick_clear), 32'h0);
    @(posedge tb_clk);
    #1;
    rst       = 1'b0;
    serial_in = 1'b1;
    tick();
    tick();
    check("post_reset_busy", 32'(busy), 32'h0);
    check("post_reset_enable_clear", 32'({tick_enable, tick_clear}), 32'h0);
    check("post_reset_status", 32'({data_ready, framing_error, overrun_error}), 32'h0);

    // Good frame, then read.
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    gap(3);
    read_pulse();
    gap(3);

    // Bad stop bit, then a frame whose start edge clears the error.
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    gap(4);
    send_frame(8'h5A, 1'b1, 1'b0, -1);
    gap(2);
    read_pulse();
    gap(2);

    // Glitch on an idle line.
    false_start();

    // Overrun, then overrun averted by a read coinciding with the stop completion.
    send_frame(8'h11, 1'b1, 1'b0, -1);
    gap(3);
    send_frame(8'h22, 1'b1, 1'b0, -1);
    gap(3);
    read_pulse();
    gap(2);
    send_frame(8'h11, 1'b1, 1'b0, -1);
    gap(3);
    send_frame(8'h22, 1'b1, 1'b1, -1);
    gap(3);
    read_pulse();
    gap(2);

    // Reset during the 4th data bit.
    send_frame(8'h99, 1'b1, 1'b0, OS * 4 + 1);
    rst       = 1'b1;
    serial_in = 1'b1;
    #1;
    check("midframe_reset_busy", 32'(busy), 32'h0);
    check("midframe_reset_enable", 32'(tick_enable), 32'h0);
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    gap(3);
    send_frame(8'h0F, 1'b1, 1'b0, -1);
    gap(3);

    // Randomised traffic.
    for (int i = 0; i < 20; i++) begin
      rb = N'($urandom_range(0, (1 << N) - 1));
      rs = ($urandom_range(0, 3) != 0);
      rr = 1'($urandom_range(0, 1));
      send_frame(rb, rs, rr, -1);
      gap($urandom_range(2, 6));
      if ($urandom_range(0, 2) == 0) begin
        read_pulse();
        gap($urandom_range(2, 4));
      end
    end

    gap(10);
    check("pending_results", 32'(res_q.size()), 32'h0);
    check("pending_tick_clears", 32'(tc_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_sequencer.md
Name: uart_rx_sequencer

Overview:
- Serial-receive sequencer that consumes the one-cycle rollover pulse of the upstream oversampling flex counter as its sample tick.
- Drives that counter's clear and count_enable to resynchronise the counter to each start edge.
- Deframes start, data and stop bits into a parallel byte, with ready, framing and overrun status for the downstream consumer.

Parameters:
NUM_DATA_BITS, 8, data bits per frame, LSB first (legal 5-9)
OVERSAMPLE, 4, sample ticks per bit time (even, >=2); upstream counter rollover_val is set to match the baud divider

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
serial_in  input  1  asynchronous serial line, idle high
sample_tick  input  1  one-cycle pulse from upstream counter rollover_flag
tick_clear  output  1  one-cycle clear pulse to upstream counter
tick_enable  output  1  count_enable to upstream counter
data_read  input  1  one-cycle pulse: consumer has taken data_out
data_out  output  NUM_DATA_BITS  last good received word
data_ready  output  1  data_out holds unread word
framing_error  output  1  last frame had stop bit 0
overrun_error  output  1  word overwritten before being read
busy  output  1  frame reception in progress

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - state IDLE.
  - Synchroniser flops and edge-history flop set to 1.
  - All outputs 0; data_out 0; shift register 0; tick counter 0; bit counter 0.
- Input path:
  - serial_in passes through a 2-flop synchroniser, then one history flop.
  - Falling edge = history 1 and synchronised 0.
- Tick counter: internal, width clog2(OVERSAMPLE)+1. Increments only on sample_tick while not IDLE.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tick_enable 0, busy 0.
  - On falling edge: next cycle tick_clear=1 for exactly one cycle, tick_enable=1, busy=1, tick counter cleared, framing_error cleared, state START.
  - Latency: serial_in low at posedge k, tick_clear high during the cycle after posedge k+3.
- START:
  - On the sample_tick that brings the tick counter to OVERSAMPLE/2, sample the synchronised line.
  - Line 0: tick counter to 0, bit counter to 0, state DATA.
  - Line 1 (false start): state IDLE, no status change.
- DATA:
  - On each sample_tick bringing the tick counter to OVERSAMPLE, sample the line, shift in LSB first, tick counter to 0, bit counter +1.
  - After NUM_DATA_BITS samples: state STOP.
- STOP: on the sample_tick bringing the tick counter to OVERSAMPLE, sample the line.
  - Line 1: data_out <= shift register; data_ready <= 1. If data_ready was already 1 and data_read is not asserted this cycle, overrun_error <= 1.
  - Line 0: framing_error <= 1; data_out, data_ready and overrun_error unchanged.
  - Either case: state IDLE, tick_enable 0.
- Re-arm: after a stop bit of 0 the line must return high before a new edge is recognised; this is implicit in the history flop.
- data_read: clears data_ready and overrun_error next edge.
- data_read coincident with a good STOP completion: new word loaded, data_ready stays 1, overrun_error not set.
- sample_tick is ignored in IDLE.
- sample_tick held high continuously is legal; each high cycle counts as one tick.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: rst=1 for 2 cycles with serial_in toggling -> data_out=0x00, data_ready=0, framing_error=0, overrun_error=0, busy=0, tick_enable=0; all remain 0 for 2 cycles after release with serial_in=1.
- Good frame: bench drives sample_tick=1 every cycle (bit = 4 cycles), sends start, 0xA5 LSB first, stop=1 -> tick_clear one pulse after the edge; data_out=0xA5, data_ready=1, busy=0 after STOP; data_read pulse -> data_ready=0.
- Framing error: send 0x3C with stop=0 after the step above -> framing_error=1, data_out stays 0xA5, data_ready unchanged.
- Next start edge -> framing_error=0.
- False start: serial_in low for 1 cycle then high -> busy rises then falls at mid-start sample, data_ready=0, data_out unchanged.
- Overrun: send 0x11 then 0x22 with no data_read -> data_out=0x22, data_ready=1, overrun_error=1.
- Overrun, coincident read: repeat the overrun scenario with data_read asserted in the STOP-completion cycle -> overrun_error=0, data_ready=1.
- Reset mid-frame: assert rst during the 4th data bit -> busy=0, tick_enable=0 immediately; then full frame 0x0F -> data_out=0x0F, no errors.
